// File: rtl/cluster_periph_demux_pkg.sv
// Shared cluster peripheral constants: plug IDs, plug count, error read data
// and the demux occupancy states.
package cluster_periph_demux_pkg;

  localparam int unsigned NB_SPERIPH_PLUGS_EU = 2;

  localparam int unsigned SPER_EOC_ID         = 0;
  localparam int unsigned SPER_TIMER_ID       = 1;
  localparam int unsigned SPER_EVENT_U_ID     = 2;
  localparam int unsigned SPER_HWPE_ID        = 3;
  localparam int unsigned SPER_ICACHE_CTRL_ID = 4;
  localparam int unsigned SPER_DMA_ID         = 5;
  localparam int unsigned SPER_EXT_ID         = 6;
  localparam int unsigned SPER_DECOMP_ID      = 7;
  localparam int unsigned SPER_NB             = 8;

  localparam logic [31:0] SPER_ERR_RDATA = 32'hBADACCE5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FULL
  } demux_state_e;

endpackage

// File: rtl/cluster_periph_demux_tracker.sv
// Outstanding-transaction tracker: owner ID, in-flight count, stall decision
// and the one-cycle error-slave response register.
module cluster_periph_demux_tracker
  import cluster_periph_demux_pkg::*;
#(
  parameter int unsigned NB_SPERIPH      = SPER_NB,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_WIDTH        = $clog2(SPER_NB + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [ID_WIDTH-1:0] tgt,
  input  logic                hs,
  input  logic                rsp,
  output logic                stall_c,
  output logic [ID_WIDTH-1:0] cur_id,
  output logic                err_pend
);

  localparam int unsigned         CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [ID_WIDTH-1:0]  ERR_ID   = ID_WIDTH'(NB_SPERIPH);

  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic [ID_WIDTH-1:0]  cur_id_d;
  logic                 err_pend_d;
  demux_state_e         state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      cur_id   <= '0;
      err_pend <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      cur_id   <= cur_id_d;
      err_pend <= err_pend_d;
    end
  end

  // Occupancy state is a view of cnt; stall uses registered state only.
  always_comb begin
    state      = ST_IDLE;
    stall_c    = 1'b0;
    cnt_d      = cnt;
    cur_id_d   = cur_id;
    err_pend_d = 1'b0;

    if (cnt == CNT_MAX) begin
      state = ST_FULL;
    end else if (cnt != '0) begin
      state = ST_BUSY;
    end

    unique case (state)
      ST_FULL: stall_c = req;
      ST_BUSY: stall_c = req && (tgt != cur_id);
      default: stall_c = 1'b0;
    endcase

    if (hs) begin
      cur_id_d   = tgt;
      err_pend_d = (tgt == ERR_ID);
    end

    // A stray response with nothing in flight must not wrap the counter.
    if (hs && !rsp) begin
      cnt_d = cnt + CNT_WIDTH'(1);
    end else if (!hs && rsp && (cnt != '0)) begin
      cnt_d = cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cluster_periph_demux.sv
// Routes the cluster peripheral master port to NB_SPERIPH slave plugs,
// keeps responses in order and answers unmapped IDs with an error.
module cluster_periph_demux
  import cluster_periph_demux_pkg::*;
#(
  parameter int unsigned           NB_SPERIPH      = SPER_NB,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           SEL_LSB         = 10,
  parameter int unsigned           SEL_WIDTH       = 4,
  parameter int unsigned           MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = DATA_WIDTH'(SPER_ERR_RDATA)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    m_req_i,
  output logic                    m_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m_add_i,
  input  logic                    m_wen_i,
  input  logic [DATA_WIDTH/8-1:0] m_be_i,
  input  logic [DATA_WIDTH-1:0]   m_wdata_i,
  output logic                    m_r_valid_o,
  output logic [DATA_WIDTH-1:0]   m_r_rdata_o,
  output logic                    m_r_opc_o,

  output logic [NB_SPERIPH-1:0]   s_req_o,
  input  logic [NB_SPERIPH-1:0]   s_gnt_i,
  output logic [ADDR_WIDTH-1:0]   s_add_o   [NB_SPERIPH],
  output logic [NB_SPERIPH-1:0]   s_wen_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o    [NB_SPERIPH],
  output logic [DATA_WIDTH-1:0]   s_wdata_o [NB_SPERIPH],
  input  logic [NB_SPERIPH-1:0]   s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   s_r_rdata_i [NB_SPERIPH],
  input  logic [NB_SPERIPH-1:0]   s_r_opc_i
);

  localparam int unsigned         ID_WIDTH  = $clog2(NB_SPERIPH + 1);
  localparam int unsigned         IDX_WIDTH = (NB_SPERIPH > 1) ? $clog2(NB_SPERIPH) : 1;
  localparam logic [ID_WIDTH-1:0] ERR_ID    = ID_WIDTH'(NB_SPERIPH);

  logic [SEL_WIDTH-1:0] sel;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic [IDX_WIDTH-1:0] cur_idx;
  logic                 mapped;
  logic [ID_WIDTH-1:0]  tgt;
  logic [ID_WIDTH-1:0]  cur_id;
  logic                 stall;
  logic                 hs;
  logic                 err_pend;

  assign sel     = m_add_i[SEL_LSB +: SEL_WIDTH];
  assign mapped  = (32'(sel) < NB_SPERIPH);
  assign sel_idx = IDX_WIDTH'(sel);
  assign tgt     = mapped ? ID_WIDTH'(sel) : ERR_ID;
  assign cur_idx = IDX_WIDTH'(cur_id);
  assign hs      = m_req_i & m_gnt_o;

  for (genvar i = 0; i < int'(NB_SPERIPH); i++) begin : g_bcast
    assign s_add_o[i]   = m_add_i;
    assign s_wen_o[i]   = m_wen_i;
    assign s_be_o[i]    = m_be_i;
    assign s_wdata_o[i] = m_wdata_i;
  end

  // Request path: the internal error slave always grants.
  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (!stall) begin
      if (mapped) begin
        s_req_o[sel_idx] = m_req_i;
        m_gnt_o          = s_gnt_i[sel_idx];
      end else begin
        m_gnt_o = 1'b1;
      end
    end
  end

  // Response path: only the owning target may answer.
  always_comb begin
    m_r_valid_o = 1'b0;
    m_r_rdata_o = '0;
    m_r_opc_o   = 1'b0;
    if (!rst_i) begin
      if (cur_id == ERR_ID) begin
        if (err_pend) begin
          m_r_valid_o = 1'b1;
          m_r_rdata_o = ERR_RDATA;
          m_r_opc_o   = 1'b1;
        end
      end else if (s_r_valid_i[cur_idx]) begin
        m_r_valid_o = 1'b1;
        m_r_rdata_o = s_r_rdata_i[cur_idx];
        m_r_opc_o   = s_r_opc_i[cur_idx];
      end
    end
  end

  cluster_periph_demux_tracker #(
    .NB_SPERIPH      (NB_SPERIPH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .ID_WIDTH        (ID_WIDTH)
  ) u_tracker (
    .clk      (clk_i),
    .rst      (rst_i),
    .req      (m_req_i),
    .tgt      (tgt),
    .hs       (hs),
    .rsp      (m_r_valid_o),
    .stall_c  (stall),
    .cur_id   (cur_id),
    .err_pend (err_pend)
  );

endmodule

// File: tb/tb_cluster_periph_demux.sv
// Scoreboard bench for cluster_periph_demux: directed scenarios then random
// traffic against a transaction-level model of in-order routing.
module tb_cluster_periph_demux;

  localparam int NB        = 8;
  localparam int SEL_LSB   = 10;
  localparam int SEL_WIDTH = 4;
  localparam int MAX       = 4;
  localparam logic [31:0] ERR_DATA = 32'hBADACCE5;

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        opc;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        opc;
    int          due;
  } rsp_t;

  logic          clk, rst_i;
  logic          m_req_i, m_gnt_o, m_wen_i, m_r_valid_o, m_r_opc_o;
  logic [31:0]   m_add_i, m_wdata_i, m_r_rdata_o;
  logic [3:0]    m_be_i;
  logic [NB-1:0] s_req_o, s_gnt_i, s_wen_o, s_r_valid_i, s_r_opc_i;
  logic [31:0]   s_add_o [NB];
  logic [3:0]    s_be_o [NB];
  logic [31:0]   s_wdata_o [NB];
  logic [31:0]   s_r_rdata_i [NB];

  req_t req_q[$];
  rsp_t exp_q[$];
  rsp_t slv_q[NB][$];

  int   n, cur, cyc, checks, errors, spur_id, last_sel, bk;
  bit   errp, mon_en, rnd_mode, hold_rsp;
  bit   exp_gnt, exp_valid;
  logic [NB-1:0] exp_sreq;
  rsp_t mon_e;

  cluster_periph_demux #(
    .NB_SPERIPH      (NB),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .SEL_LSB         (SEL_LSB),
    .SEL_WIDTH       (SEL_WIDTH),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .m_req_i     (m_req_i),
    .m_gnt_o     (m_gnt_o),
    .m_add_i     (m_add_i),
    .m_wen_i     (m_wen_i),
    .m_be_i      (m_be_i),
    .m_wdata_i   (m_wdata_i),
    .m_r_valid_o (m_r_valid_o),
    .m_r_rdata_o (m_r_rdata_o),
    .m_r_opc_o   (m_r_opc_o),
    .s_req_o     (s_req_o),
    .s_gnt_i     (s_gnt_i),
    .s_add_o     (s_add_o),
    .s_wen_o     (s_wen_o),
    .s_be_o      (s_be_o),
    .s_wdata_o   (s_wdata_o),
    .s_r_valid_i (s_r_valid_i),
    .s_r_rdata_i (s_r_rdata_i),
    .s_r_opc_i   (s_r_opc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Slave ID field of an address; out-of-range IDs collapse onto the error slave.
  function automatic int tgt_of(input logic [31:0] a);
    int s;
    s = int'((a >> SEL_LSB) & ((32'd1 << SEL_WIDTH) - 32'd1));
    return (s >= NB) ? NB : s;
  endfunction

  function automatic req_t mk_req(input int s, input logic wen, input logic [31:0] rd, input logic op);
    req_t q;
    q.add   = ($urandom() & ~(32'hF << SEL_LSB)) | (32'(s) << SEL_LSB);
    q.wen   = wen;
    q.be    = 4'($urandom());
    q.wdata = $urandom();
    q.rdata = rd;
    q.opc   = op;
    return q;
  endfunction

  // Output checker: compares every cycle and pops the scoreboard on each response.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_gnt", 128'(m_gnt_o), 128'(exp_gnt));
      chk("s_req", 128'(s_req_o), 128'(exp_sreq));
      chk("r_valid", 128'(m_r_valid_o), 128'(exp_valid));
      bk = cyc % NB;
      chk("bcast", 128'({s_add_o[bk], s_wen_o[bk], s_be_o[bk], s_wdata_o[bk]}),
          128'({m_add_i, m_wen_i, m_be_i, m_wdata_i}));
      if (m_r_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected: got response %0h, expected none (cycle %0d)", m_r_rdata_o, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("r_rdata", 128'(m_r_rdata_o), 128'(mon_e.rdata));
          chk("r_opc", 128'(m_r_opc_o), 128'(mon_e.opc));
        end
      end
    end
  end

  // One bus cycle: drive master and slaves, predict, then advance the model.
  task automatic cycle();
    int   tgt, sp;
    bit   rq, stall, hs;
    bit   real_rsp [NB];
    rsp_t r;

    rq = (req_q.size() != 0);
    if (rq) begin
      m_add_i   = req_q[0].add;
      m_wen_i   = req_q[0].wen;
      m_be_i    = req_q[0].be;
      m_wdata_i = req_q[0].wdata;
    end else begin
      m_add_i   = $urandom();
      m_wen_i   = 1'($urandom_range(1));
      m_be_i    = 4'($urandom());
      m_wdata_i = $urandom();
    end
    m_req_i     = rq;
    s_r_valid_i = '0;
    for (int k = 0; k < NB; k++) begin
      s_gnt_i[k]     = rnd_mode ? ($urandom_range(3) != 0) : 1'b1;
      s_r_rdata_i[k] = $urandom();
      s_r_opc_i[k]   = 1'($urandom_range(1));
      real_rsp[k]    = 1'b0;
      if (!hold_rsp && slv_q[k].size() != 0 && slv_q[k][0].due <= cyc &&
          (!rnd_mode || $urandom_range(3) != 0)) begin
        real_rsp[k]    = 1'b1;
        s_r_valid_i[k] = 1'b1;
        s_r_rdata_i[k] = slv_q[k][0].rdata;
        s_r_opc_i[k]   = slv_q[k][0].opc;
      end
    end
    sp = spur_id;
    if (spur_id == NB) sp = ($urandom_range(7) == 0) ? int'($urandom_range(NB - 1)) : -1;
    if (sp >= 0 && sp != cur && slv_q[sp].size() == 0) s_r_valid_i[sp] = 1'b1;

    tgt       = tgt_of(m_add_i);
    stall     = rq && (n == MAX || (n != 0 && tgt != cur));
    exp_gnt   = stall ? 1'b0 : ((tgt == NB) ? 1'b1 : s_gnt_i[tgt]);
    exp_sreq  = '0;
    if (rq && !stall && tgt < NB) exp_sreq[tgt] = 1'b1;
    exp_valid = (cur == NB) ? errp : s_r_valid_i[cur];
    hs        = rq && exp_gnt;

    @(negedge clk);
    #1;
    for (int k = 0; k < NB; k++) if (real_rsp[k]) slv_q[k].delete(0);
    if (hs) begin
      if (tgt == NB) begin
        r = '{rdata: ERR_DATA, opc: 1'b1, due: 0};
      end else begin
        r = '{rdata: req_q[0].rdata, opc: req_q[0].opc,
              due: cyc + (rnd_mode ? int'($urandom_range(6, 1)) : 2)};
        slv_q[tgt].push_back(r);
      end
      exp_q.push_back(r);
      cur = tgt;
      req_q.delete(0);
    end
    errp = hs && (tgt == NB);
    n    = n + int'(hs) - int'(exp_valid);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int nc);
    for (int i = 0; i < nc; i++) cycle();
  endtask

  task automatic drain(input int budget);
    int i;
    i        = 0;
    hold_rsp = 1'b0;
    while ((n != 0 || req_q.size() != 0) && i < budget) begin
      cycle();
      i++;
    end
    if (n != 0 || req_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0 within %0d cycles", n, budget);
    end
  endtask

  initial begin
    req_t rr;
    int   s, r;
    checks = 0; errors = 0; n = 0; cur = 0; cyc = 0; errp = 1'b0;
    mon_en = 1'b0; rnd_mode = 1'b0; hold_rsp = 1'b0; spur_id = -1; last_sel = 0;
    exp_gnt = 1'b0; exp_valid = 1'b0; exp_sreq = '0;

    // In reset: responses suppressed, request path still combinational.
    rst_i       = 1'b1;
    rr          = mk_req(0, 1'b1, 32'h0, 1'b0);
    m_req_i     = 1'b1;
    m_add_i     = rr.add;
    m_wen_i     = 1'b1;
    m_be_i      = 4'hF;
    m_wdata_i   = 32'h0;
    s_gnt_i     = '1;
    s_r_valid_i = '0;
    s_r_valid_i[0] = 1'b1;
    s_r_opc_i   = '1;
    for (int k = 0; k < NB; k++) s_r_rdata_i[k] = 32'h5A5A0000 + 32'(k);
    #12;
    chk("rst_r_valid", 128'(m_r_valid_o), 128'(0));
    chk("rst_r_rdata", 128'(m_r_rdata_o), 128'(0));
    chk("rst_r_opc", 128'(m_r_opc_o), 128'(0));
    chk("rst_gnt", 128'(m_gnt_o), 128'(1));
    chk("rst_s_req", 128'(s_req_o), 128'(8'h01));
    @(negedge clk);
    rst_i       = 1'b0;
    m_req_i     = 1'b0;
    s_r_valid_i = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Timer read, response two cycles later.
    req_q.push_back(mk_req(1, 1'b1, 32'h1234, 1'b0));
    run(5);

    // Fill to the outstanding limit on one slave, then release.
    hold_rsp = 1'b1;
    repeat (5) req_q.push_back(mk_req(6, 1'b1, $urandom(), 1'b0));
    run(7);
    drain(40);

    // Different target while busy must wait for the owner to finish.
    hold_rsp = 1'b1;
    req_q.push_back(mk_req(6, 1'b1, $urandom(), 1'b0));
    run(2);
    req_q.push_back(mk_req(2, 1'b0, $urandom(), 1'b1));
    run(3);
    drain(40);

    // Unmapped IDs, back to back, then a mapped request behind them.
    req_q.push_back(mk_req(12, 1'b1, 32'h0, 1'b0));
    req_q.push_back(mk_req(12, 1'b0, 32'h0, 1'b0));
    req_q.push_back(mk_req(15, 1'b1, 32'h0, 1'b0));
    req_q.push_back(mk_req(1, 1'b1, $urandom(), 1'b0));
    drain(40);

    // Stray valid from a slave that does not own the transaction.
    hold_rsp = 1'b1;
    req_q.push_back(mk_req(5, 1'b1, $urandom(), 1'b0));
    run(2);
    spur_id = 3;
    run(3);
    spur_id = -1;
    drain(40);

    // Asynchronous reset with three reads in flight.
    hold_rsp = 1'b1;
    repeat (3) req_q.push_back(mk_req(4, 1'b1, $urandom(), 1'b0));
    run(4);
    mon_en         = 1'b0;
    m_req_i        = 1'b0;
    s_r_valid_i    = '0;
    s_r_valid_i[4] = 1'b1;
    s_r_rdata_i[4] = 32'hAAAA5555;
    s_r_opc_i[4]   = 1'b1;
    #1;
    chk("pre_rst_valid", 128'(m_r_valid_o), 128'(1));
    chk("pre_rst_rdata", 128'(m_r_rdata_o), 128'(32'hAAAA5555));
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 128'(m_r_valid_o), 128'(0));
    chk("async_rst_rdata", 128'(m_r_rdata_o), 128'(0));
    chk("async_rst_opc", 128'(m_r_opc_o), 128'(0));
    @(posedge clk);
    #4;
    rst_i       = 1'b0;
    s_r_valid_i = '0;
    n = 0; cur = 0; errp = 1'b0;
    req_q.delete();
    exp_q.delete();
    for (int k = 0; k < NB; k++) slv_q[k].delete();
    @(posedge clk);
    #1;
    mon_en   = 1'b1;
    hold_rsp = 1'b0;
    req_q.push_back(mk_req(5, 1'b1, $urandom(), 1'b0));
    drain(40);

    // Random traffic with random grants, latencies and stray responses.
    rnd_mode = 1'b1;
    spur_id  = NB;
    for (int i = 0; i < 1500; i++) begin
      if (req_q.size() == 0 && $urandom_range(2) != 0) begin
        r = int'($urandom_range(9));
        if (r < 2)      s = int'($urandom_range(15, NB));
        else if (r < 6) s = last_sel;
        else            s = int'($urandom_range(NB - 1));
        last_sel = s;
        req_q.push_back(mk_req(s, 1'($urandom_range(1)), $urandom(), 1'($urandom_range(7) == 0)));
      end
      cycle();
    end
    spur_id = -1;
    drain(300);

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
